// File: rtl/param_stream_pkg.sv
// Shared types and width helpers for the parameter-ROM streaming controller.
package param_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Bits needed to hold any count in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/param_stream_fifo.sv
// Synchronous FIFO with flush; dout is the head entry, valid while not empty.
// Push on a full FIFO is accepted when a pop happens in the same cycle.
module param_stream_fifo
    import param_stream_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int WIDTH = 16,
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/param_stream_ctrl.sv
// Streams a parameter tensor from a fixed-latency ROM through a small FIFO with a valid/ready output.
// First beat ROM_LATENCY+1 cycles after start; reads are throttled so no beat is lost. Optional PARAM_STREAM_PERF_EN.
module param_stream_ctrl
    import param_stream_pkg::*;
#(
    parameter int PRECISION   = 16,
    parameter int PARALLELISM = 1,
    parameter int OUT_DEPTH   = 32,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = ROM_LATENCY + 1,
    parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH + 1),
    parameter int PASS_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [PASS_WIDTH-1:0]            passes,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_WIDTH-1:0]            rom_addr,
    output logic                             rom_ce,
    input  logic [PRECISION*PARALLELISM-1:0] rom_q,
    output logic [PRECISION-1:0]             data_out [PARALLELISM],
    output logic                             data_out_valid,
    input  logic                             data_out_ready
`ifdef PARAM_STREAM_PERF_EN
    ,
    output logic [31:0]                      stall_cycles,
    output logic [31:0]                      beats_out
`endif
);

    localparam int W   = PRECISION * PARALLELISM;
    localparam int FCW = cnt_width(FIFO_DEPTH);
    localparam int IW  = cnt_width(ROM_LATENCY);
    localparam int SW  = cnt_width(FIFO_DEPTH + ROM_LATENCY + 1);

    state_t                 state;
    state_t                 state_nx;
    logic [PASS_WIDTH-1:0]  passes_q;
    logic [PASS_WIDTH-1:0]  pass_cnt;
    logic [ROM_LATENCY-1:0] vpipe;
    logic [IW-1:0]          inflight;
    logic [FCW-1:0]         fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [W-1:0]           fifo_dout;
    logic                   issue;
    logic                   room;
    logic                   pop;
    logic                   push;
    logic                   flush;
    logic                   last_addr;
    logic                   last_pass;

    assign busy           = (state != IDLE);
    assign rom_ce         = busy;
    assign data_out_valid = !fifo_empty;
    assign pop            = data_out_valid && data_out_ready;
    assign push           = vpipe[ROM_LATENCY-1];
    assign flush          = abort && busy;
    assign last_addr      = (rom_addr == ADDR_WIDTH'(OUT_DEPTH - 1));
    assign last_pass      = (passes_q != '0) && (pass_cnt + PASS_WIDTH'(1) == passes_q);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight = inflight + IW'(vpipe[i]);
        end
    end

    // Buffered plus in-flight beats must fit the FIFO; a pop this cycle frees one slot.
    assign room = (SW'(fifo_count) + SW'(inflight)) < (SW'(FIFO_DEPTH) + SW'(pop));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                if (abort) begin
                    state_nx = DRAIN;
                end else begin
                    issue = room;
                    if (room && last_addr && last_pass) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!abort && inflight == '0 && fifo_empty) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            pass_cnt <= '0;
            passes_q <= '0;
            vpipe    <= '0;
        end else begin
            if (state == IDLE && start) begin
                rom_addr <= '0;
                pass_cnt <= '0;
                passes_q <= passes;
            end else if (issue) begin
                if (last_addr) begin
                    rom_addr <= '0;
                    pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                end else begin
                    rom_addr <= rom_addr + ADDR_WIDTH'(1);
                end
            end
            vpipe <= flush ? '0 : ((vpipe << 1) | ROM_LATENCY'(issue));
        end
    end

    param_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (rom_q),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        for (int j = 0; j < PARALLELISM; j++) begin
            data_out[j] = fifo_dout[PRECISION*j +: PRECISION];
        end
    end

`ifdef PARAM_STREAM_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            stall_cycles <= '0;
            beats_out    <= '0;
        end else begin
            if (data_out_valid && !data_out_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (pop && beats_out != '1)
                beats_out <= beats_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_param_stream_ctrl.sv
// Directed bench for param_stream_ctrl: ROM model, expected-beat model and one compare process.
module tb_param_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] passes;
    logic        abort;
    logic        busy;
    logic        done;
    logic [5:0]  rom_addr;
    logic        rom_ce;
    logic [15:0] rom_q;
    logic [15:0] data_out [1];
    logic        data_out_valid;
    logic        data_out_ready;
`ifdef PARAM_STREAM_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] beats_out;
`endif

    param_stream_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .passes         (passes),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .rom_addr       (rom_addr),
        .rom_ce         (rom_ce),
        .rom_q          (rom_q),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
`ifdef PARAM_STREAM_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .beats_out      (beats_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input logic [5:0] a);
        return 16'hA500 + {10'd0, a};
    endfunction

    // Two-register ROM, advancing only while clock-enabled.
    logic [15:0] q1;
    logic [15:0] q2;
    always @(posedge clk) begin
        if (rom_ce) begin
            q1 <= rom_fn(rom_addr);
            q2 <= q1;
        end
    end
    assign rom_q = q2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Model state: beat k of any stream must carry rom_fn(k mod 32).
    int          test_id = 0;
    int          seen_id = 0;
    int          exp_idx = 0;
    int          hs_count = 0;
    int          done_count = 0;
    int          last_hs_cyc = 0;
    int          done_cyc = 0;
    int          max_occ = 0;
    logic [15:0] last_data = '0;
    logic        prev_stall = 1'b0;
    logic        prev_abort = 1'b0;
    logic [15:0] prev_data = '0;

    always @(negedge clk) begin
        if (test_id != seen_id) begin
            seen_id    = test_id;
            exp_idx    = 0;
            hs_count   = 0;
            done_count = 0;
            max_occ    = 0;
            prev_stall = 1'b0;
        end
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !prev_abort) begin
                check("stall_valid_held", int'(data_out_valid), 1);
                check("stall_data_held", int'(data_out[0]), int'(prev_data));
            end
            if (data_out_valid && data_out_ready) begin
                check("beat_value", int'(data_out[0]), int'(rom_fn(6'(exp_idx % 32))));
                exp_idx++;
                hs_count++;
                last_hs_cyc = cyc;
                last_data   = data_out[0];
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (int'(dut.fifo_count) > max_occ) max_occ = int'(dut.fifo_count);
            prev_stall = data_out_valid && !data_out_ready;
            prev_data  = data_out[0];
        end
        prev_abort = abort;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_stream(input logic [15:0] p);
        passes = p;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    // pat 0: ready held high; pat 1: ready toggles every cycle.
    task automatic run(input int pat, input int max_cyc);
        int n = 0;
        while (done_count == 0 && n < max_cyc) begin
            step();
            n++;
            data_out_ready = (pat == 1) ? n[0] : 1'b1;
        end
        check("done_seen", (done_count != 0) ? 1 : 0, 1);
    endtask

    task automatic wait_hs(input int target, input int max_cyc);
        int n = 0;
        while (hs_count < target && n < max_cyc) begin
            step();
            n++;
        end
        check("hs_reached", (hs_count >= target) ? 1 : 0, 1);
    endtask

    initial begin
        int lat;
        int a;
        int n;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        passes = '0;
        data_out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(data_out_valid), 0);
        check("rst_rom_ce", int'(rom_ce), 0);
        check("rst_rom_addr", int'(rom_addr), 0);

        // Single pass, ready high: latency, order, done timing.
        test_id = 1;
        data_out_ready = 1'b1;
        start_stream(16'd1);
        lat = 0;
        while (!data_out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("first_valid_latency", lat, 3);
        check("first_beat", int'(data_out[0]), 16'hA500);
        run(0, 200);
        check("t1_beats", hs_count, 32);
        check("t1_last_beat", int'(last_data), 16'hA51F);
        check("t1_done_after_last_hs", done_cyc - last_hs_cyc, 1);
        step();
        step();
        check("t1_done_once", done_count, 1);
        check("t1_idle", int'(busy), 0);

        // Two passes, ready toggling.
        test_id = 2;
        start_stream(16'd2);
        run(1, 400);
        check("t2_beats", hs_count, 64);
        check("t2_fifo_bound", (max_occ <= 3) ? 1 : 0, 1);
        step();
        check("t2_done_once", done_count, 1);

        // Long stall mid-stream.
        test_id = 3;
        data_out_ready = 1'b1;
        start_stream(16'd1);
        wait_hs(8, 100);
        data_out_ready = 1'b0;
        repeat (10) step();
        a = int'(rom_addr);
        repeat (10) step();
        check("t3_addr_frozen", int'(rom_addr), a);
        check("t3_addr_issued", int'(rom_addr), 11);
        check("t3_hs_during_stall", hs_count, 8);
        data_out_ready = 1'b1;
        run(0, 200);
        check("t3_beats", hs_count, 32);
        check("t3_last_beat", int'(last_data), 16'hA51F);

        // Abort after 10 beats with ready low.
        test_id = 4;
        data_out_ready = 1'b1;
        start_stream(16'd1);
        wait_hs(10, 100);
        data_out_ready = 1'b0;
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_valid_dropped", int'(data_out_valid), 0);
        check("t4_busy_draining", int'(busy), 1);
        n = 0;
        while (done_count == 0 && n < 3) begin
            step();
            n++;
        end
        check("t4_done_in_time", done_count, 1);
        repeat (3) step();
        check("t4_done_once", done_count, 1);
        check("t4_idle", int'(busy), 0);
        check("t4_beats", hs_count, 10);

        // Reset during a continuous stream, then a clean restart.
        test_id = 5;
        data_out_ready = 1'b1;
        start_stream(16'd0);
        repeat (40) step();
        check("t5_busy", int'(busy), 1);
        check("t5_rom_ce", int'(rom_ce), 1);
        check("t5_wrapped", (hs_count > 32) ? 1 : 0, 1);
        rst = 1'b1;
        step();
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_done", int'(done), 0);
        check("t5_rst_valid", int'(data_out_valid), 0);
        check("t5_rst_rom_ce", int'(rom_ce), 0);
        check("t5_rst_rom_addr", int'(rom_addr), 0);
        rst = 1'b0;
        step();
        test_id = 6;
        start_stream(16'd1);
        run(0, 200);
        check("t6_beats", hs_count, 32);
        check("t6_last_beat", int'(last_data), 16'hA51F);

`ifdef PARAM_STREAM_PERF_EN
        test_id = 7;
        data_out_ready = 1'b1;
        start_stream(16'd1);
        wait_hs(5, 100);
        data_out_ready = 1'b0;
        repeat (5) step();
        data_out_ready = 1'b1;
        run(0, 200);
        check("perf_beats_out", int'(beats_out), 32);
        check("perf_stall_cycles", int'(stall_cycles), 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
